// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared types and helpers for the multi-channel pattern PWM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_e;

   // One spare bit so the channel index can also encode out-of-range values.
   function automatic int ch_idx_w(input int num_ch);
      return $clog2(num_ch) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_pattern_ch.sv
// ============================================================================
// Module  : pwm_pattern_ch
// Brief   : One pattern PWM channel: shadow/active config, FSM and counters.
//           Optional output inversion under MPWM_POLARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_pattern_ch
   import pwm_pkg::*;
#(
   parameter int PAT_WIDTH = 32,
   parameter int DUTY_W    = 8,
   parameter int GAP_W     = 16,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef MPWM_POLARITY_EN
   input  logic                 cfg_inv,
`endif
   input  logic                 cfg_we,
   input  logic [DUTY_W-1:0]    cfg_duty,
   input  logic [GAP_W-1:0]     cfg_gap,
   input  logic [CNT_W-1:0]     cfg_num,
   input  logic [PAT_WIDTH-1:0] cfg_pat,
   input  logic                 start,
   input  logic                 stop,
   output logic                 pwm_out,
   output logic                 busy,
   output logic                 valid
);

   localparam int BIT_W = $clog2(PAT_WIDTH);
   localparam logic [BIT_W-1:0] c_msb = BIT_W'(PAT_WIDTH - 1);

   typedef struct packed {
      logic [DUTY_W-1:0]    duty;
      logic [GAP_W-1:0]     gap;
      logic [CNT_W-1:0]     num;
      logic [PAT_WIDTH-1:0] pat;
      logic                 inv;
   } cfg_t;

   cfg_t              w_cfg_in, r_shadow, r_active, w_active_nxt;
   state_e            r_state, w_state_nxt;
   logic [BIT_W-1:0]  r_bit, w_bit_nxt;
   logic [DUTY_W-1:0] r_hold, w_hold_nxt, w_hold_lim;
   logic [CNT_W-1:0]  r_burst, w_burst_nxt;
   logic [GAP_W-1:0]  r_gap_cnt, w_gap_nxt;
   logic              w_last_burst, w_valid_nxt, w_pwm_nxt, w_busy_nxt;
   logic              r_pwm, r_busy, r_valid;

   always_comb begin
      w_cfg_in.duty = cfg_duty;
      w_cfg_in.gap  = cfg_gap;
      w_cfg_in.num  = cfg_num;
      w_cfg_in.pat  = cfg_pat;
`ifdef MPWM_POLARITY_EN
      w_cfg_in.inv  = cfg_inv;
`else
      w_cfg_in.inv  = 1'b0;
`endif
   end

   // A duty of zero is treated as one clock per bit.
   assign w_hold_lim   = (r_active.duty == '0) ? '0 : r_active.duty - DUTY_W'(1);
   assign w_last_burst = (r_active.num != '0) &&
                         (((CNT_W+1)'(r_burst) + (CNT_W+1)'(1)) == {1'b0, r_active.num});

   always_comb begin
      w_state_nxt  = r_state;
      w_active_nxt = r_active;
      w_bit_nxt    = r_bit;
      w_hold_nxt   = r_hold;
      w_burst_nxt  = r_burst;
      w_gap_nxt    = r_gap_cnt;
      w_valid_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_active_nxt = r_shadow;
               w_bit_nxt    = c_msb;
               w_hold_nxt   = '0;
               w_burst_nxt  = '0;
               w_gap_nxt    = '0;
               w_state_nxt  = RUN;
            end
         end
         RUN: begin
            if (r_hold == w_hold_lim) begin
               w_hold_nxt = '0;
               if (r_bit == '0) begin
                  if (w_last_burst) begin
                     w_state_nxt = IDLE;
                     w_valid_nxt = 1'b1;
                  end else begin
                     if (r_burst != '1) w_burst_nxt = r_burst + CNT_W'(1);
                     w_bit_nxt = c_msb;
                     if (r_active.gap != '0) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = '0;
                     end
                  end
               end else begin
                  w_bit_nxt = r_bit - BIT_W'(1);
               end
            end else begin
               w_hold_nxt = r_hold + DUTY_W'(1);
            end
         end
         GAP: begin
            if (r_gap_cnt == r_active.gap - GAP_W'(1)) begin
               w_state_nxt = RUN;
               w_bit_nxt   = c_msb;
               w_hold_nxt  = '0;
            end else begin
               w_gap_nxt = r_gap_cnt + GAP_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Abort overrides everything, including a same-cycle start.
      if (stop) begin
         w_state_nxt  = IDLE;
         w_active_nxt = r_active;
         w_valid_nxt  = 1'b0;
      end
      w_busy_nxt = (w_state_nxt != IDLE);
      w_pwm_nxt  = ((w_state_nxt == RUN) ? w_active_nxt.pat[w_bit_nxt] : 1'b0) ^ w_active_nxt.inv;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow  <= '0;
         r_active  <= '0;
         r_state   <= IDLE;
         r_bit     <= '0;
         r_hold    <= '0;
         r_burst   <= '0;
         r_gap_cnt <= '0;
         r_pwm     <= 1'b0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         if (cfg_we) r_shadow <= w_cfg_in;
         r_active  <= w_active_nxt;
         r_state   <= w_state_nxt;
         r_bit     <= w_bit_nxt;
         r_hold    <= w_hold_nxt;
         r_burst   <= w_burst_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_pwm     <= w_pwm_nxt;
         r_busy    <= w_busy_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   assign pwm_out = r_pwm;
   assign busy    = r_busy;
   assign valid   = r_valid;

endmodule

`default_nettype wire

// File: rtl/multi_pattern_pwm.sv
// ============================================================================
// Module  : multi_pattern_pwm
// Brief   : N-channel pattern PWM with shared config port and start/stop masks.
//           Optional per-channel output polarity under MPWM_POLARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_pattern_pwm
   import pwm_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int PAT_WIDTH = 32,
   parameter int DUTY_W    = 8,
   parameter int GAP_W     = 16,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef MPWM_POLARITY_EN
   input  logic                    cfg_inv,
`endif
   input  logic                    cfg_we,
   input  logic [$clog2(NUM_CH):0] cfg_ch,
   input  logic [DUTY_W-1:0]       cfg_duty,
   input  logic [GAP_W-1:0]        cfg_gap,
   input  logic [CNT_W-1:0]        cfg_num,
   input  logic [PAT_WIDTH-1:0]    cfg_pat,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       valid,
   output logic                    cfg_err
);

   localparam int CH_IDX_W = ch_idx_w(NUM_CH);
   localparam logic [CH_IDX_W-1:0] c_num_ch = CH_IDX_W'(NUM_CH);

   logic r_cfg_err;

   always_ff @(posedge clk) begin
      if (rst) r_cfg_err <= 1'b0;
      else     r_cfg_err <= cfg_we && (cfg_ch >= c_num_ch);
   end

   assign cfg_err = r_cfg_err;

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         logic w_we;
         assign w_we = cfg_we && (cfg_ch == CH_IDX_W'(i));

         pwm_pattern_ch #(
            .PAT_WIDTH (PAT_WIDTH),
            .DUTY_W    (DUTY_W),
            .GAP_W     (GAP_W),
            .CNT_W     (CNT_W)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
`ifdef MPWM_POLARITY_EN
            .cfg_inv  (cfg_inv),
`endif
            .cfg_we   (w_we),
            .cfg_duty (cfg_duty),
            .cfg_gap  (cfg_gap),
            .cfg_num  (cfg_num),
            .cfg_pat  (cfg_pat),
            .start    (start[i]),
            .stop     (stop[i]),
            .pwm_out  (pwm_out[i]),
            .busy     (busy[i]),
            .valid    (valid[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_pattern_pwm.sv
// ============================================================================
// Module  : tb_multi_pattern_pwm
// Brief   : Directed self-checking bench for multi_pattern_pwm (PAT_WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_pattern_pwm;

   localparam int NUM_CH = 4;
   localparam int PW     = 8;

   logic           clk = 1'b0;
   logic           rst;
`ifdef MPWM_POLARITY_EN
   logic           cfg_inv = 1'b0;
`endif
   logic           cfg_we;
   logic [2:0]     cfg_ch;
   logic [7:0]     cfg_duty;
   logic [15:0]    cfg_gap;
   logic [7:0]     cfg_num;
   logic [PW-1:0]  cfg_pat;
   logic [3:0]     start, stop;
   logic [3:0]     pwm_out, busy, valid;
   logic           cfg_err;

   int checks   = 0;
   int failures = 0;

   multi_pattern_pwm #(.NUM_CH(NUM_CH), .PAT_WIDTH(PW)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MPWM_POLARITY_EN
      .cfg_inv  (cfg_inv),
`endif
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_duty (cfg_duty),
      .cfg_gap  (cfg_gap),
      .cfg_num  (cfg_num),
      .cfg_pat  (cfg_pat),
      .start    (start),
      .stop     (stop),
      .pwm_out  (pwm_out),
      .busy     (busy),
      .valid    (valid),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [2:0] ch, input logic [7:0] duty,
                            input logic [15:0] gap, input logic [7:0] num,
                            input logic [7:0] pat);
      cfg_ch = ch; cfg_duty = duty; cfg_gap = gap; cfg_num = num; cfg_pat = pat;
      cfg_we = 1'b1;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] mask);
      start = mask;
      cycle();
      start = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_duty = 0; cfg_gap = 0; cfg_num = 0;
      cfg_pat = 0; start = 0; stop = 0;
      cycle(); cycle();
      rst = 1'b0;
      checks++;
      if ({pwm_out, busy, valid, cfg_err} !== 13'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {pwm_out, busy, valid, cfg_err});
      end
   endtask

   task automatic test_basic();
      logic [15:0] e = 16'b1100_1100_0011_0011;
      write_cfg(3'd0, 8'd2, 16'd0, 8'd1, 8'hA5);
      pulse_start(4'b0001);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if ({pwm_out[0], busy[0], valid[0]} !== {e[15-k], 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL basic_wave k=%0d got(pwm,busy,valid)=%b exp=%b", k,
                     {pwm_out[0], busy[0], valid[0]}, {e[15-k], 2'b10});
         end
         cycle();
      end
      checks++;
      if ({pwm_out[0], busy[0], valid[0]} !== 3'b001) begin
         failures++;
         $display("FAIL basic_done got=%b exp=001", {pwm_out[0], busy[0], valid[0]});
      end
      cycle();
      checks++;
      if (valid !== 4'b0) begin
         failures++;
         $display("FAIL basic_valid_one_cycle got=%b exp=0000", valid);
      end
   endtask

   task automatic test_gap_repeat();
      logic [18:0] e = 19'b10000001_000_10000001;
      write_cfg(3'd1, 8'd1, 16'd3, 8'd2, 8'h81);
      pulse_start(4'b0010);
      for (int k = 0; k < 19; k++) begin
         checks++;
         if ({pwm_out, busy, valid} !== {2'b00, e[18-k], 1'b0, 4'b0010, 4'b0000}) begin
            failures++;
            $display("FAIL gap_wave k=%0d got(pwm,busy,valid)=%b exp=%b", k,
                     {pwm_out, busy, valid}, {2'b00, e[18-k], 1'b0, 8'b0010_0000});
         end
         cycle();
      end
      checks++;
      if ({busy, valid} !== 8'b0000_0010) begin
         failures++;
         $display("FAIL gap_done got(busy,valid)=%b exp=00000010", {busy, valid});
      end
      cycle();
      checks++;
      if (valid !== 4'b0) begin
         failures++;
         $display("FAIL gap_single_valid got=%b exp=0000", valid);
      end
   endtask

   task automatic test_sync_start();
      logic [7:0] e = 8'h3C;
      write_cfg(3'd0, 8'd1, 16'd0, 8'd1, 8'h3C);
      write_cfg(3'd2, 8'd1, 16'd0, 8'd1, 8'h3C);
      pulse_start(4'b0101);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (pwm_out !== {1'b0, e[7-k], 1'b0, e[7-k]} || busy !== 4'b0101) begin
            failures++;
            $display("FAIL sync_wave k=%0d got(pwm,busy)=%b/%b exp=%b/0101", k,
                     pwm_out, busy, {1'b0, e[7-k], 1'b0, e[7-k]});
         end
         cycle();
      end
      checks++;
      if (valid !== 4'b0101) begin
         failures++;
         $display("FAIL sync_valid got=%b exp=0101", valid);
      end
      cycle();
   endtask

   task automatic test_abort();
      logic [9:0] e = 10'b1111000000;
      write_cfg(3'd3, 8'd1, 16'd2, 8'd0, 8'hF0);
      pulse_start(4'b1000);
      for (int k = 0; k < 30; k++) begin
         checks++;
         if ({pwm_out[3], busy[3], valid[3]} !== {e[9 - (k % 10)], 2'b10}) begin
            failures++;
            $display("FAIL infinite_wave k=%0d got(pwm,busy,valid)=%b exp=%b", k,
                     {pwm_out[3], busy[3], valid[3]}, {e[9 - (k % 10)], 2'b10});
         end
         cycle();
      end
      stop = 4'b1000; start = 4'b1000;
      cycle();
      stop = '0; start = '0;
      checks++;
      if ({pwm_out[3], busy[3], valid[3]} !== 3'b000) begin
         failures++;
         $display("FAIL abort_stop got(pwm,busy,valid)=%b exp=000", {pwm_out[3], busy[3], valid[3]});
      end
      cycle();
      checks++;
      if ({pwm_out, busy, valid} !== 12'b0) begin
         failures++;
         $display("FAIL abort_no_restart got=%b exp=0", {pwm_out, busy, valid});
      end
   endtask

   task automatic test_bad_channel_shadow();
      logic [7:0] e0 = 8'h0F;
      logic [7:0] e1 = 8'hFF;
      logic [7:0] e2 = 8'h33;
      write_cfg(3'd0, 8'd1, 16'd0, 8'd1, 8'h0F);
      write_cfg(3'd4, 8'd1, 16'd0, 8'd1, 8'hAA);
      checks++;
      if ({cfg_err, pwm_out, busy, valid} !== 13'b1_0000_0000_0000) begin
         failures++;
         $display("FAIL bad_ch_err got(err,pwm,busy,valid)=%b exp=1000000000000",
                  {cfg_err, pwm_out, busy, valid});
      end
      cycle();
      checks++;
      if (cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL bad_ch_err_pulse got=%b exp=0", cfg_err);
      end
      pulse_start(4'b0001);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({pwm_out[0], busy[0]} !== {e0[7-k], 1'b1}) begin
            failures++;
            $display("FAIL shadow_busy_write k=%0d got(pwm,busy)=%b exp=%b", k,
                     {pwm_out[0], busy[0]}, {e0[7-k], 1'b1});
         end
         if (k == 2) begin
            cfg_ch = 3'd0; cfg_pat = 8'hFF; cfg_we = 1'b1; start = 4'b0001;
         end else begin
            cfg_we = 1'b0; start = '0;
         end
         cycle();
      end
      checks++;
      if (valid !== 4'b0001) begin
         failures++;
         $display("FAIL shadow_valid1 got=%b exp=0001", valid);
      end
      cfg_pat = 8'h33; cfg_we = 1'b1; start = 4'b0001;
      cycle();
      cfg_we = 1'b0; start = '0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (pwm_out[0] !== e1[7-k]) begin
            failures++;
            $display("FAIL shadow_old_on_start k=%0d got=%b exp=%b", k, pwm_out[0], e1[7-k]);
         end
         cycle();
      end
      pulse_start(4'b0001);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (pwm_out[0] !== e2[7-k]) begin
            failures++;
            $display("FAIL shadow_new_next k=%0d got=%b exp=%b", k, pwm_out[0], e2[7-k]);
         end
         cycle();
      end
      cycle();
   endtask

   task automatic test_reset_midrun_duty0();
      logic [7:0] e = 8'hC5;
      write_cfg(3'd2, 8'd1, 16'd0, 8'd0, 8'hFF);
      pulse_start(4'b0100);
      cycle(); cycle();
      checks++;
      if (busy !== 4'b0100) begin
         failures++;
         $display("FAIL midrun_busy got=%b exp=0100", busy);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if ({pwm_out, busy, valid, cfg_err} !== 13'b0) begin
         failures++;
         $display("FAIL midrun_reset got=%b exp=0", {pwm_out, busy, valid, cfg_err});
      end
      cycle();
      checks++;
      if ({pwm_out, busy, valid} !== 12'b0) begin
         failures++;
         $display("FAIL midrun_stay_idle got=%b exp=0", {pwm_out, busy, valid});
      end
      for (int d = 0; d < 2; d++) begin
         write_cfg(3'd1, 8'(d), 16'd0, 8'd1, 8'hC5);
         pulse_start(4'b0010);
         for (int k = 0; k < 8; k++) begin
            checks++;
            if ({pwm_out[1], busy[1], valid[1]} !== {e[7-k], 2'b10}) begin
               failures++;
               $display("FAIL duty%0d_wave k=%0d got=%b exp=%b", d, k,
                        {pwm_out[1], busy[1], valid[1]}, {e[7-k], 2'b10});
            end
            cycle();
         end
         checks++;
         if ({busy[1], valid[1]} !== 2'b01) begin
            failures++;
            $display("FAIL duty%0d_done got(busy,valid)=%b exp=01", d, {busy[1], valid[1]});
         end
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap_repeat();
      test_sync_start();
      test_abort();
      test_bad_channel_shadow();
      test_reset_midrun_duty0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
